// File: rtl/maze_pkg.sv
// Shared maze sizing and controller state encoding for the maze memory.
package maze_pkg;
  localparam int MAZE_WIDTH = 6;
  localparam int MAZE_DIM   = 2**MAZE_WIDTH;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    SERVE = 2'd2
  } state_t;
endpackage

// File: rtl/maze_bitplane.sv
// One N x N bitplane: row-wide write, single-bit set, combinational peek and
// registered single-bit read, all addressed by the solver's (row, col).
module maze_bitplane
  import maze_pkg::*;
#(
  parameter int W = MAZE_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              row_we,
  input  logic [W-1:0]      row_addr,
  input  logic [2**W-1:0]   row_data,
  input  logic              set_en,
  input  logic [W-1:0]      row,
  input  logic [W-1:0]      col,
  input  logic              rd_en,
  output logic              rd_o,
  output logic              bit_o
);
  localparam int N = 2**W;

  logic [N-1:0] plane_q [N];
  logic         rd_q;

  // Storage carries no reset; the controller zeroes every row after reset.
  always_ff @(posedge clk) begin
    if (row_we) begin
      plane_q[row_addr] <= row_data;
    end else if (set_en) begin
      plane_q[row][col] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
    end else if (rd_en) begin
      rd_q <= plane_q[row][col];
    end
  end

  assign bit_o = plane_q[row][col];
  assign rd_o  = rd_q;
endmodule

// File: rtl/maze_mem.sv
// Maze memory: wall and visited planes with clear/load/serve sequencing.
// Build option MAZE_MEM_WALL_GUARD_EN blocks visited writes onto walls and flags them.
//
// state | meaning
// CLEAR | zero one row of both planes per cycle, rows 0..N-1
// LOAD  | accept one wall row per load_valid, rows 0..N-1
// SERVE | solver reads walls and marks visited cells until reset
module maze_mem
  import maze_pkg::*;
#(
  parameter int maze_width = MAZE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    load_valid,
  input  logic [2**maze_width-1:0] load_data,
  output logic                    load_ready,
  output logic                    maze_ready,
  output logic [2*maze_width:0]   path_cnt,
  output logic                    wall_hit
);
  localparam int N  = 2**maze_width;
  localparam int CW = 2*maze_width + 1;

  state_t                state_q;
  logic [maze_width-1:0] ptr_q;
  logic                  load_ready_q;
  logic                  maze_ready_q;
  logic [CW-1:0]         path_cnt_q;

  logic         in_clear, in_load, serve;
  logic         wall_row_we;
  logic [N-1:0] wall_row_data;
  logic         wall_bit, vis_bit;
  logic         vis_set, cnt_inc;
  logic         vis_rd_unused;

  assign in_clear      = (state_q == CLEAR);
  assign in_load       = (state_q == LOAD);
  assign serve         = (state_q == SERVE);
  assign wall_row_we   = in_clear | (in_load & load_valid);
  assign wall_row_data = in_load ? load_data : '0;

  maze_bitplane #(.W(maze_width)) u_walls (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_we   (wall_row_we),
    .row_addr (ptr_q),
    .row_data (wall_row_data),
    .set_en   (1'b0),
    .row      (row),
    .col      (col),
    .rd_en    (serve & maze_oe),
    .rd_o     (maze_in),
    .bit_o    (wall_bit)
  );

  maze_bitplane #(.W(maze_width)) u_visited (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_we   (in_clear),
    .row_addr (ptr_q),
    .row_data ('0),
    .set_en   (vis_set),
    .row      (row),
    .col      (col),
    .rd_en    (1'b0),
    .rd_o     (vis_rd_unused),
    .bit_o    (vis_bit)
  );

`ifdef MAZE_MEM_WALL_GUARD_EN
  logic wall_hit_q;

  assign vis_set = serve & maze_we & ~wall_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wall_hit_q <= 1'b0;
    end else if (serve & maze_we & wall_bit) begin
      wall_hit_q <= 1'b1;
    end
  end

  assign wall_hit = wall_hit_q;
`else
  assign vis_set  = serve & maze_we;
  assign wall_hit = 1'b0;
`endif

  // Only a fresh mark on a free cell counts as path progress.
  assign cnt_inc = vis_set & ~vis_bit & ~wall_bit & (path_cnt_q != CW'(N*N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      maze_ready_q <= 1'b0;
      path_cnt_q   <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + maze_width'(1);
          if (&ptr_q) begin
            state_q      <= LOAD;
            load_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr_q <= ptr_q + maze_width'(1);
            if (&ptr_q) begin
              state_q      <= SERVE;
              load_ready_q <= 1'b0;
              maze_ready_q <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (cnt_inc) begin
            path_cnt_q <= path_cnt_q + CW'(1);
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign maze_ready = maze_ready_q;
  assign path_cnt   = path_cnt_q;
endmodule

// File: doc/maze_mem.md
MAZE_MEM -- requirements
Module: maze_mem

Interface
REQ-001 SHALL have parameter: maze_width, default 6, bits per row/col coordinate; maze side N = 2**maze_width.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: row, col  input  maze_width  cell selected by the solver.
REQ-005 SHALL have port: maze_oe  input  1  read enable, sampled at clk edge.
REQ-006 SHALL have port: maze_we  input  1  write (mark-visited) enable, sampled at clk edge.
REQ-007 SHALL have port: maze_in  output  1  registered cell content; 1 = wall, 0 = free.
REQ-008 SHALL have ports: load_valid  input  1; load_data  input  N  one maze row, bit c = wall at column c; load_ready  output  1.
REQ-009 SHALL have ports: maze_ready  output  1  maze loaded and serving; path_cnt  output  2*maze_width+1  distinct visited free cells.
REQ-010 SHALL have port: wall_hit  output  1  sticky write-to-wall flag (see REQ-025).

Function
REQ-011 SHALL hold two N x N bitplanes: walls and visited.
REQ-012 SHALL use FSM states CLEAR, LOAD, SERVE; CLEAR is the reset state.
REQ-013 CLEAR SHALL zero one row of both planes per cycle, rows 0..N-1, then go to LOAD (N cycles).
REQ-014 LOAD SHALL assert load_ready; each cycle with load_valid=1 writes load_data into wall row load_ptr, load_ptr increments from 0.
REQ-015 After the handshake with load_ptr = N-1, FSM SHALL go to SERVE; load_ready drops the next cycle; load_valid while load_ready=0 is ignored.
REQ-016 SERVE SHALL assert maze_ready; maze_oe/maze_we outside SERVE are ignored.
REQ-017 maze_oe=1 at edge k SHALL present walls[row][col] on maze_in after edge k (1-cycle latency); maze_in holds its value when maze_oe=0.
REQ-018 maze_we=1 at edge k SHALL set visited[row][col]; walls never change in SERVE.
REQ-019 path_cnt SHALL increment by 1 only when a write sets a previously clear visited bit on a free cell; saturates at N*N.
REQ-020 Simultaneous maze_oe and maze_we on the same cell SHALL both take effect; maze_in returns the wall bit (unaffected by the write).
REQ-021 Coordinates SHALL be unsigned, no wrap logic needed (full range maps to valid cells).
REQ-022 SERVE SHALL persist until rst_n asserts; no other exit.

Reset
REQ-023 rst_n=0 SHALL immediately force: state CLEAR, load_ptr 0, maze_in 0, load_ready 0, maze_ready 0, path_cnt 0, wall_hit 0.
REQ-024 Reset mid-LOAD or mid-SERVE SHALL discard all content; after release the full CLEAR then LOAD sequence repeats.

Configuration
REQ-025 Macro MAZE_MEM_WALL_GUARD_EN: defined -> write to a wall cell leaves visited unchanged and sets wall_hit (sticky until reset); undefined -> such writes set visited, path_cnt unaffected, wall_hit tied 0.

Structure
REQ-026 Package maze_pkg SHALL hold MAZE_WIDTH, MAZE_DIM, and the FSM state enum (CLEAR, LOAD, SERVE).
REQ-027 Sub-module maze_bitplane SHALL implement one N x N plane: row-wide write/clear, single-bit set, single-bit registered read; instantiated twice.

Verification
REQ-028 Reset, release: maze_ready=0 for 64 cycles of CLEAR, then load_ready=1; path_cnt=0.
REQ-029 Load 64 rows with row 5 = 0x...0010 (bit 4 set), others 0: oe at (5,4) -> maze_in=1 next cycle; oe at (5,3) -> maze_in=0.
REQ-030 In SERVE, we at (10,10) twice, then (10,11): path_cnt=2.
REQ-031 oe+we same cycle at free (7,7): maze_in=0 next cycle, path_cnt +1.
REQ-032 Guard on, we at wall (5,4): wall_hit=1, path_cnt unchanged; guard off: wall_hit=0, path_cnt unchanged.
REQ-033 Assert rst_n=0 after 30 loaded rows: all outputs 0 at once; reload completes normally.
